// File: rtl/fwd_sel_if.sv
// rtl/fwd_sel_if.sv - ID-stage hazard/forwarding bundle for fwd_sel_ctrl
// Ports (slave = controller side):
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
//   id_rd, id_reg_write, id_mem_read, flush   : ID-stage instruction info
//   stall                                     : combinational load-use stall
//   ex_valid, fwd_a_sel, fwd_b_sel            : registered EX-stage controls
interface fwd_sel_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  stall, ex_valid, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output stall, ex_valid, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - forwarding select and load-use stall controller
// Tracks destination tags through EX/MEM/WB and produces registered
// operand-mux selects for EX (00 regfile, 01 EX/MEM, 10 MEM/WB,
// 11 retired latch) plus a combinational load-use stall.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fwd_sel_if.slave (ID inputs, stall, ex_valid, fwd_a_sel, fwd_b_sel)
module fwd_sel_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic    clk,
  input  logic    rst,
  fwd_sel_if.slave bus
);

  logic              ex_v, ex_wr, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_wr;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_v, wb_wr;
  logic [REG_AW-1:0] wb_rd;
  logic [1:0]        a_sel_q, b_sel_q;

  logic [1:0]        a_sel_d, b_sel_d;
  logic              load_use;
  logic              bubble;

  function automatic logic tag_hit(input logic v, input logic wr,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] r);
    return v & wr & (rd == r) & (r != '0);
  endfunction

  // Youngest producer first: EX, then MEM, then the retired WB tag.
  function automatic logic [1:0] sel_code(input logic use_r,
                                          input logic [REG_AW-1:0] r,
                                          input logic h_ex,
                                          input logic h_mem,
                                          input logic h_wb);
    if (!use_r || r == '0) return 2'b00;
    else if (h_ex)         return 2'b01;
    else if (h_mem)        return 2'b10;
    else if (h_wb)         return 2'b11;
    else                   return 2'b00;
  endfunction

  always_comb begin
    a_sel_d = sel_code(bus.id_use_rs1, bus.id_rs1,
                       tag_hit(ex_v,  ex_wr,  ex_rd,  bus.id_rs1),
                       tag_hit(mem_v, mem_wr, mem_rd, bus.id_rs1),
                       tag_hit(wb_v,  wb_wr,  wb_rd,  bus.id_rs1));
    b_sel_d = sel_code(bus.id_use_rs2, bus.id_rs2,
                       tag_hit(ex_v,  ex_wr,  ex_rd,  bus.id_rs2),
                       tag_hit(mem_v, mem_wr, mem_rd, bus.id_rs2),
                       tag_hit(wb_v,  wb_wr,  wb_rd,  bus.id_rs2));
  end

  // A load result is not available until MEM, so a dependent instruction
  // right behind it must wait one cycle; flush kills the consumer instead.
  assign load_use = bus.id_valid & ~bus.flush & ex_v & ex_ld & ex_wr &
                    (ex_rd != '0) &
                    ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd)) |
                     (bus.id_use_rs2 & (bus.id_rs2 == ex_rd)));

  assign bubble = bus.flush | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v    <= 1'b0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      ex_rd   <= '0;
      mem_v   <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= '0;
      wb_v    <= 1'b0;
      wb_wr   <= 1'b0;
      wb_rd   <= '0;
      a_sel_q <= 2'b00;
      b_sel_q <= 2'b00;
    end else begin
      // Downstream stages always advance; only EX is bubbled on a stall.
      wb_v   <= mem_v;
      wb_wr  <= mem_wr;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (bubble) begin
        ex_v    <= 1'b0;
        ex_wr   <= 1'b0;
        ex_ld   <= 1'b0;
        ex_rd   <= '0;
        a_sel_q <= 2'b00;
        b_sel_q <= 2'b00;
      end else begin
        ex_v    <= bus.id_valid;
        ex_wr   <= bus.id_reg_write;
        ex_ld   <= bus.id_mem_read;
        ex_rd   <= bus.id_rd;
        a_sel_q <= a_sel_d;
        b_sel_q <= b_sel_d;
      end
    end
  end

  assign bus.stall     = load_use;
  assign bus.ex_valid  = ex_v;
  assign bus.fwd_a_sel = a_sel_q;
  assign bus.fwd_b_sel = b_sel_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - scoreboard bench for fwd_sel_ctrl
module tb_fwd_sel_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_sel_if #(.REG_AW(5)) bus ();

  fwd_sel_ctrl #(.REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       r;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic       e_exv;
    logic [1:0] e_a;
    logic [1:0] e_b;
  } vec_t;

  vec_t       vecs[$];
  logic       stall_q[$];
  int         stall_idx_q[$];
  logic [4:0] ex_q[$];
  int         ex_idx_q[$];
  int         passed = 0;
  int         total  = 0;

  task automatic add_vec(input logic r, input logic v,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic wr,
                         input logic ld, input logic fl,
                         input logic es, input logic ev,
                         input logic [1:0] ea, input logic [1:0] eb);
    vec_t t;
    t = '{r, v, rs1, rs2, u1, u2, rd, wr, ld, fl, es, ev, ea, eb};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %0b expected %0b", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t t);
    rst              = t.r;
    bus.id_valid     = t.v;
    bus.id_rs1       = t.rs1;
    bus.id_rs2       = t.rs2;
    bus.id_use_rs1   = t.u1;
    bus.id_use_rs2   = t.u2;
    bus.id_rd        = t.rd;
    bus.id_reg_write = t.wr;
    bus.id_mem_read  = t.ld;
    bus.flush        = t.fl;
  endtask

  // Monitor: stall is checked in its own cycle, EX controls one cycle later.
  initial begin
    logic       es;
    logic [4:0] ee;
    int         si, ei;
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        es = stall_q.pop_front();
        si = stall_idx_q.pop_front();
        check("stall", si, {1'b0, bus.stall}, {1'b0, es});
      end
      if (ex_q.size() > 0) begin
        ee = ex_q.pop_front();
        ei = ex_idx_q.pop_front();
        check("ex_valid", ei, {1'b0, bus.ex_valid}, {1'b0, ee[4]});
        check("fwd_a_sel", ei, bus.fwd_a_sel, ee[3:2]);
        check("fwd_b_sel", ei, bus.fwd_b_sel, ee[1:0]);
      end
    end
  end

  initial begin
    vec_t idle;
    idle = '0;
    drive(idle);
    rst = 1'b1;

    //        r  v  rs1 rs2 u1 u2 rd  wr ld fl  stl exv a      b
    add_vec(1, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 0 reset
    add_vec(1, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 1 reset
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 2 idle
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 3 idle
    add_vec(0, 1, 1,  2,  1, 1, 5,  1, 0, 0,  0,  1,  2'b00, 2'b00); // 4 add x5
    add_vec(0, 1, 5,  6,  1, 1, 10, 1, 0, 0,  0,  1,  2'b01, 2'b00); // 5 sub x5,x6
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 6
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 7
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 8
    add_vec(0, 1, 0,  0,  0, 0, 7,  1, 0, 0,  0,  1,  2'b00, 2'b00); // 9 wr x7 (d3)
    add_vec(0, 1, 0,  0,  0, 0, 7,  1, 0, 0,  0,  1,  2'b00, 2'b00); // 10 wr x7 (d2)
    add_vec(0, 1, 0,  0,  0, 0, 11, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 11 filler
    add_vec(0, 1, 7,  0,  1, 1, 12, 1, 0, 0,  0,  1,  2'b10, 2'b00); // 12 read x7
    add_vec(0, 1, 0,  0,  0, 0, 7,  1, 0, 0,  0,  1,  2'b00, 2'b00); // 13 wr x7 (d3)
    add_vec(0, 1, 0,  0,  0, 0, 13, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 14
    add_vec(0, 1, 0,  0,  0, 0, 14, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 15
    add_vec(0, 1, 7,  7,  1, 0, 15, 1, 0, 0,  0,  1,  2'b11, 2'b00); // 16 read x7
    add_vec(0, 1, 0,  0,  0, 0, 8,  1, 1, 0,  0,  1,  2'b00, 2'b00); // 17 lw x8
    add_vec(0, 1, 1,  8,  1, 1, 16, 1, 0, 0,  1,  0,  2'b00, 2'b00); // 18 add stalls
    add_vec(0, 1, 1,  8,  1, 1, 16, 1, 0, 0,  0,  1,  2'b00, 2'b10); // 19 add held
    add_vec(0, 1, 0,  0,  0, 0, 0,  1, 0, 0,  0,  1,  2'b00, 2'b00); // 20 wr x0
    add_vec(0, 1, 0,  0,  1, 1, 17, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 21 read x0
    add_vec(0, 1, 0,  0,  0, 0, 0,  1, 1, 0,  0,  1,  2'b00, 2'b00); // 22 lw x0
    add_vec(0, 1, 0,  0,  1, 1, 19, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 23 read x0
    add_vec(0, 1, 0,  0,  0, 0, 3,  1, 1, 0,  0,  1,  2'b00, 2'b00); // 24 lw x3
    add_vec(0, 1, 3,  3,  0, 0, 18, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 25 unused x3
    add_vec(0, 1, 0,  0,  0, 0, 9,  1, 1, 0,  0,  1,  2'b00, 2'b00); // 26 lw x9
    add_vec(0, 1, 9,  2,  1, 1, 20, 1, 0, 1,  0,  0,  2'b00, 2'b00); // 27 dep + flush
    add_vec(0, 1, 9,  2,  1, 1, 20, 1, 0, 0,  0,  1,  2'b10, 2'b00); // 28 read x9
    add_vec(0, 1, 0,  0,  0, 0, 21, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 29 wr x21
    add_vec(0, 1, 0,  0,  0, 0, 21, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 30 wr x21
    add_vec(0, 1, 20, 21, 1, 1, 22, 1, 0, 0,  0,  1,  2'b11, 2'b01); // 31 mask older
    add_vec(0, 1, 21, 0,  1, 0, 23, 1, 0, 1,  0,  0,  2'b00, 2'b00); // 32 flush
    add_vec(0, 1, 0,  0,  0, 0, 22, 1, 1, 0,  0,  1,  2'b00, 2'b00); // 33 lw x22
    add_vec(1, 0, 22, 22, 1, 1, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 34 reset
    add_vec(0, 1, 22, 22, 1, 1, 24, 1, 0, 0,  0,  1,  2'b00, 2'b00); // 35 no fwd
    add_vec(0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  0,  2'b00, 2'b00); // 36 idle

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      if (i > 0) begin
        ex_q.push_back({vecs[i-1].e_exv, vecs[i-1].e_a, vecs[i-1].e_b});
        ex_idx_q.push_back(i - 1);
      end
      #1;
      drive(vecs[i]);
      stall_q.push_back(vecs[i].e_stall);
      stall_idx_q.push_back(i);
    end
    @(posedge clk);
    ex_q.push_back({vecs[vecs.size()-1].e_exv, vecs[vecs.size()-1].e_a,
                    vecs[vecs.size()-1].e_b});
    ex_idx_q.push_back(vecs.size() - 1);
    #1;
    drive(idle);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (stall_q.size() == 0 && ex_q.size() == 0) passed++;
    else $display("FAIL drain: stall_q=%0d ex_q=%0d expected 0 0",
                  stall_q.size(), ex_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
